// File: rtl/regffte_pkg.sv
// Shared types and default sizing for the FFT-energy register-file sequencer.
package regffte_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_DEPTH     = 64;
  localparam int DEF_NUM_BANKS = 2;

  // Bank index width; a single bank still needs a 1-bit port.
  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regffte_seq_ctrl_if.sv
// Start requests in, register-file address/bank/strobes and status out; no flow control.
interface regffte_seq_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int BANK_W = 1
);
  logic              sroot_en;
  logic              addmel_en;
  logic [ADDR_W-1:0] regffte_addr;
  logic [BANK_W-1:0] regffte_bank;
  logic              regffte_wren;
  logic              regffte_rden;
  logic              sweep_done;
  logic              busy;
  logic              seq_err;

  modport master (
    input  sroot_en, addmel_en,
    output regffte_addr, regffte_bank, regffte_wren, regffte_rden,
           sweep_done, busy, seq_err
  );

  modport slave (
    output sroot_en, addmel_en,
    input  regffte_addr, regffte_bank, regffte_wren, regffte_rden,
           sweep_done, busy, seq_err
  );
endinterface

// File: rtl/regffte_edge_det.sv
// Rising-edge detector on a level request; combinational rise output, one sample flop.
// Disarmed for the first cycle after reset so a level held through reset is not an edge.
module regffte_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_o
);
  logic prev_q, prev_d;
  logic arm_q, arm_d;

  always_comb begin
    prev_d = din;
    arm_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end

  assign rise_o = arm_q & din & ~prev_q;
endmodule

// File: rtl/regffte_seq_ctrl.sv
// Write/read sweep sequencer over a banked FFT-energy register file; registered outputs, first strobe one cycle after a start edge.
// Optional REGFFTE_STALL_EN adds a stall input that freezes an active sweep with strobes low.
module regffte_seq_ctrl
  import regffte_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_BANKS = DEF_NUM_BANKS
) (
  input  logic clk,
  input  logic rst_n,
`ifdef REGFFTE_STALL_EN
  input  logic stall,
`endif
  regffte_seq_ctrl_if.master bus
);
  localparam int BANK_W = bank_w(NUM_BANKS);
  localparam int CNT_W  = ADDR_W + 1;

  logic stall_w;
`ifdef REGFFTE_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  logic wr_rise, rd_rise;

  regffte_edge_det u_wr_edge (.clk(clk), .rst_n(rst_n), .din(bus.sroot_en),  .rise_o(wr_rise));
  regffte_edge_det u_rd_edge (.clk(clk), .rst_n(rst_n), .din(bus.addmel_en), .rise_o(rd_rise));

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              wren_q, wren_d;
  logic              rden_q, rden_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [BANK_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [BANK_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]        fill_q, fill_d;
  // Number of entries already issued in the current sweep (0..DEPTH).
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic wr_ok, rd_ok;
  assign wr_ok = (fill_q < 3'(NUM_BANKS));
  assign rd_ok = (fill_q != 3'd0);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    bank_d   = bank_q;
    wren_d   = 1'b0;
    rden_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        bank_d = wr_ptr_q;
        if (wr_rise && wr_ok) begin
          state_d = ST_WR;
          wren_d  = 1'b1;
          cnt_d   = CNT_W'(1);
        end else begin
          if (wr_rise) err_d = 1'b1;
          if (rd_rise) begin
            if (rd_ok) begin
              state_d = ST_RD;
              bank_d  = rd_ptr_q;
              rden_d  = 1'b1;
              cnt_d   = CNT_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end

      ST_WR, ST_RD: begin
        if (stall_w) begin
          // Hold the last issued address with strobes low.
        end else if (cnt_q == CNT_W'(DEPTH)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          addr_d  = '0;
          if (state_q == ST_WR) begin
            wr_ptr_d = (wr_ptr_q == BANK_W'(NUM_BANKS - 1)) ? '0 : wr_ptr_q + 1'b1;
            fill_d   = fill_q + 3'd1;
          end else begin
            rd_ptr_d = (rd_ptr_q == BANK_W'(NUM_BANKS - 1)) ? '0 : rd_ptr_q + 1'b1;
            fill_d   = fill_q - 3'd1;
          end
        end else begin
          addr_d = cnt_q[ADDR_W-1:0];
          wren_d = (state_q == ST_WR);
          rden_d = (state_q == ST_RD);
          cnt_d  = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        addr_d  = '0;
        bank_d  = wr_ptr_q;
        cnt_d   = '0;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      bank_q   <= '0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      bank_q   <= bank_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.regffte_addr = addr_q;
  assign bus.regffte_bank = bank_q;
  assign bus.regffte_wren = wren_q;
  assign bus.regffte_rden = rden_q;
  assign bus.sweep_done   = done_q;
  assign bus.busy         = busy_q;
  assign bus.seq_err      = err_q;
endmodule

// File: tb/tb_regffte_seq_ctrl.sv
// Scoreboard bench for regffte_seq_ctrl: expected strobes queued at each start, checked as they appear.
module tb_regffte_seq_ctrl;
  import regffte_pkg::*;

  localparam int ADDR_W    = DEF_ADDR_W;
  localparam int DEPTH     = DEF_DEPTH;
  localparam int NUM_BANKS = DEF_NUM_BANKS;
  localparam int BANK_W    = bank_w(NUM_BANKS);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
`ifdef REGFFTE_STALL_EN
  logic stall = 1'b0;
`endif

  always #5 clk = ~clk;

  regffte_seq_ctrl_if #(.ADDR_W(ADDR_W), .BANK_W(BANK_W)) bus ();

  regffte_seq_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_BANKS(NUM_BANKS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef REGFFTE_STALL_EN
    .stall (stall),
`endif
    .bus   (bus)
  );

  typedef struct packed {
    logic              rd;
    logic [BANK_W-1:0] bank;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_chk      = 0;
  int   n_pass     = 0;
  int   strobe_cnt = 0;
  int   base_cnt   = 0;
  int   mdl_wr     = 0;
  int   mdl_rd     = 0;
  int   mdl_fill   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Strobe monitor: every strobe must match the head of the scoreboard.
  exp_t mon_got;
  always @(negedge clk) begin
    if (rst_n && (bus.regffte_wren || bus.regffte_rden)) begin
      strobe_cnt++;
      mon_got = '{rd: bus.regffte_rden, bank: bus.regffte_bank, addr: bus.regffte_addr};
      if (bus.regffte_wren && bus.regffte_rden)
        chk("both_strobes", 32'(mon_got), 32'hFFFF_FFFF);
      else if (sb.size() == 0)
        chk("unexpected_strobe", 32'(mon_got), 32'hFFFF_FFFF);
      else
        chk("strobe", 32'(mon_got), 32'(sb.pop_front()));
    end
  end

  task automatic chk_all_zero(input string tag);
    chk(tag, {bus.regffte_addr, bus.regffte_bank, bus.regffte_wren, bus.regffte_rden,
              bus.sweep_done, bus.busy, bus.seq_err}, 32'd0);
  endtask

  task automatic start_sweep(input bit is_rd, input bit both, input bit hold);
    @(negedge clk);
    if (is_rd) bus.addmel_en = 1'b1;
    else       bus.sroot_en  = 1'b1;
    if (both)  bus.addmel_en = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      sb.push_back('{rd: is_rd, bank: BANK_W'(is_rd ? mdl_rd : mdl_wr), addr: ADDR_W'(i)});
    base_cnt = strobe_cnt;
    @(negedge clk);
    if (!hold) begin
      bus.sroot_en  = 1'b0;
      bus.addmel_en = 1'b0;
    end
  endtask

  task automatic finish_sweep(input bit is_rd);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      if (bus.sweep_done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_outputs", {bus.regffte_wren, bus.regffte_rden, bus.regffte_addr}, 32'd0);
    chk("sweep_strobes", 32'(strobe_cnt - base_cnt), 32'(DEPTH));
    if (is_rd) begin
      mdl_rd = (mdl_rd + 1) % NUM_BANKS;
      mdl_fill--;
    end else begin
      mdl_wr = (mdl_wr + 1) % NUM_BANKS;
      mdl_fill++;
    end
    @(negedge clk);
    chk("idle_state", {bus.busy, bus.sweep_done, bus.regffte_wren, bus.regffte_rden}, 32'd0);
    chk("idle_bank", 32'(bus.regffte_bank), 32'(mdl_wr));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic pulse(input bit sroot, input bit addmel);
    @(negedge clk);
    bus.sroot_en  = sroot;
    bus.addmel_en = addmel;
    @(negedge clk);
    bus.sroot_en  = 1'b0;
    bus.addmel_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    mdl_wr = 0; mdl_rd = 0; mdl_fill = 0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    bus.sroot_en  = 1'b1;
    bus.addmel_en = 1'b0;

    // Reset state, with a start level held high through deassertion.
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("level_thru_reset", {bus.busy, bus.regffte_wren, bus.seq_err}, 32'd0);
    bus.sroot_en = 1'b0;
    @(negedge clk);

    // Write bank 0 with level held high across the sweep (no retrigger), then read it.
    start_sweep(1'b0, 1'b0, 1'b1);
    finish_sweep(1'b0);
    repeat (3) @(negedge clk);
    chk("held_no_retrigger", 32'(bus.busy), 32'd0);
    bus.sroot_en = 1'b0;
    start_sweep(1'b1, 1'b0, 1'b0);
    finish_sweep(1'b1);

    // Reset mid-write at addr 30.
    start_sweep(1'b0, 1'b0, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (bus.regffte_wren && bus.regffte_addr == ADDR_W'(30)) found = 1'b1;
    end
    chk("reached_addr30", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    sb.delete();
    mdl_wr = 0; mdl_rd = 0; mdl_fill = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh write starts at bank 0, addr 0 (optionally stalled at addr 10).
    start_sweep(1'b0, 1'b0, 1'b0);
`ifdef REGFFTE_STALL_EN
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (bus.regffte_wren && bus.regffte_addr == ADDR_W'(10)) found = 1'b1;
      else @(negedge clk);
    end
    chk("reached_addr10", 32'(found), 32'd1);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_hold", {bus.regffte_addr, bus.regffte_wren}, {ADDR_W'(10), 1'b0});
    end
    stall = 1'b0;
`endif
    finish_sweep(1'b0);

    // Both edges with fill 1: write to bank 1 only, no error.
    start_sweep(1'b0, 1'b1, 1'b0);
    finish_sweep(1'b0);
    chk("both_edges_no_err", 32'(bus.seq_err), 32'd0);

    // Drain both banks in order.
    start_sweep(1'b1, 1'b0, 1'b0);
    finish_sweep(1'b1);
    start_sweep(1'b1, 1'b0, 1'b0);
    finish_sweep(1'b1);

    // Write with a read edge mid-sweep: ignored, not queued, no error.
    start_sweep(1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    bus.addmel_en = 1'b1;
    @(negedge clk);
    bus.addmel_en = 1'b0;
    finish_sweep(1'b0);
    repeat (3) @(negedge clk);
    chk("mid_edge_ignored", {bus.busy, bus.seq_err}, 32'd0);

    // Fill both banks, then a third write is refused.
    start_sweep(1'b0, 1'b0, 1'b0);
    finish_sweep(1'b0);
    chk("fill_full", 32'(mdl_fill), 32'(NUM_BANKS));
    pulse(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("overflow_err", {bus.seq_err, bus.busy}, 32'b10);

    // Read with empty buffer sets the error.
    do_reset();
    repeat (2) @(negedge clk);
    chk("err_cleared", 32'(bus.seq_err), 32'd0);
    pulse(1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("underflow_err", {bus.seq_err, bus.busy}, 32'b10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regffte_seq_ctrl.md
REGFFTE_SEQ_CTRL -- requirements
Module: regffte_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, 6, register-file address width.
REQ-002 Parameter DEPTH, 64, entries per sweep; legal range 2..2^ADDR_W.
REQ-003 Parameter NUM_BANKS, 2, FFT-energy buffer banks; legal range 1..4; BANK_W = max(1, clog2(NUM_BANKS)).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 sroot_en  in  1  level; rising edge requests a write sweep (sqrt results into register file).
REQ-007 addmel_en  in  1  level; rising edge requests a read sweep (feeds mel accumulation).
REQ-008 stall  in  1  pauses the active sweep; present only with REGFFTE_STALL_EN.
REQ-009 regffte_addr  out  ADDR_W  current entry address.
REQ-010 regffte_bank  out  BANK_W  bank being written or read.
REQ-011 regffte_wren  out  1  write strobe, aligned with addr and bank.
REQ-012 regffte_rden  out  1  read strobe, aligned with addr and bank.
REQ-013 sweep_done  out  1  one-cycle pulse after the last entry of either sweep.
REQ-014 busy  out  1  high in WR, RD and DONE.
REQ-015 seq_err  out  1  sticky sequencing-error flag, cleared only by reset.

Function
REQ-016 The FSM SHALL have the states IDLE, WR, RD and DONE; all outputs SHALL be registered.
REQ-017 Each start request SHALL be detected as a rising edge against the previous-cycle sample; a level held high SHALL not retrigger.
REQ-018 In IDLE, a sroot_en edge with fill < NUM_BANKS SHALL enter WR; with fill == NUM_BANKS it SHALL be ignored and set seq_err.
REQ-019 In IDLE, an addmel_en edge with fill > 0 SHALL enter RD; with fill == 0 it SHALL be ignored and set seq_err.
REQ-020 When both edges arrive in the same IDLE cycle and the write is legal, write SHALL win and the read request SHALL be dropped without error; if the write is illegal, read is evaluated per REQ-019 and seq_err is set.
REQ-021 WR SHALL assert wren for exactly DEPTH non-stalled cycles, addr 0..DEPTH-1, bank = wr_ptr; first strobe in the cycle after edge detection.
REQ-022 RD SHALL behave identically with rden, bank = rd_ptr.
REQ-023 After the last entry the FSM SHALL enter DONE for one cycle: sweep_done = 1, strobes = 0, addr = 0; then IDLE.
REQ-024 A completed write SHALL advance wr_ptr modulo NUM_BANKS and increment fill; a completed read SHALL advance rd_ptr modulo NUM_BANKS and decrement fill.
REQ-025 Start edges arriving in WR, RD or DONE SHALL be ignored, not queued, and SHALL not set seq_err.
REQ-026 addr SHALL never exceed DEPTH-1; no wrap occurs inside a sweep.
REQ-027 In IDLE, regffte_bank SHALL hold wr_ptr, and both strobes SHALL be 0.

Reset
REQ-028 Asserting rst_n low at any time, including mid-sweep, SHALL immediately force: state IDLE, addr 0, bank 0, wren 0, rden 0, sweep_done 0, busy 0, seq_err 0, wr_ptr 0, rd_ptr 0, fill 0, edge samples 0; a partially written bank is discarded.
REQ-029 A start level held high through reset deassertion SHALL not count as an edge.

Configuration
REQ-030 With REGFFTE_STALL_EN defined: in WR or RD with stall = 1, state, addr and counters SHALL hold and strobes SHALL be 0 that cycle; stall in IDLE or DONE has no effect.
REQ-031 Without REGFFTE_STALL_EN: the stall port SHALL be absent, and sweeps SHALL run uninterrupted for DEPTH cycles.

Structure
REQ-032 A shared package regffte_pkg SHALL hold the FSM state typedef and the default ADDR_W, DEPTH and NUM_BANKS constants.
REQ-033 The rising-edge detector SHALL be a sub-module regffte_edge_det, instantiated once per start input.

Verification
REQ-034 Defaults; sroot_en edge -> wren high 64 cycles, addr 0..63, bank 0; sweep_done pulse; fill = 1.
REQ-035 Then an addmel_en edge -> rden high 64 cycles on bank 0; sweep_done; fill = 0; rd_ptr = 1.
REQ-036 Three write sweeps with no read, NUM_BANKS = 2 -> third request ignored, seq_err = 1, no wren.
REQ-037 Both edges in the same IDLE cycle with fill = 1 -> WR on bank 1 only, seq_err stays 0.
REQ-038 rst_n low at addr 30 in WR -> all outputs 0 asynchronously; next sroot_en edge writes bank 0 from addr 0.
REQ-039 With REGFFTE_STALL_EN, stall high at addr 10 for 5 cycles -> addr holds at 10, wren 0, total strobes still 64.
